// File: rtl/event_chunk_feeder.sv
// event_chunk_feeder
// Pulls one fixed-length chunk of 64-bit words from an AXI4-Stream link source.
// A chunk is only started when the downstream 64->512 expander reports room for
// a whole chunk. Words are re-timed into gap-free groups of three, so the
// expander's 192-bit packing never sees a hole inside a group.
// Short chunks are padded with zero words and long chunks are truncated; each
// case sets its own sticky error flag.
module event_chunk_feeder #(
    parameter int CHUNK_LEN = 384,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             space_avail_i,
    output logic [63:0]      payload_o,
    output logic             payload_valid_o,
    output logic             payload_last_o,
    output logic [CNT_W-1:0] chunk_count_o,
    output logic             err_short_o,
    output logic             err_long_o,
    output logic             busy_o
);

    // Triplet output would be misaligned on the final group otherwise.
    if ((CHUNK_LEN % 3) != 0) begin : g_len_check
        $error("event_chunk_feeder: CHUNK_LEN must be a multiple of 3");
    end

    localparam int              WC_W     = $clog2(CHUNK_LEN + 1);
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(CHUNK_LEN - 1);
    localparam logic [WC_W-1:0] WC_ONE   = WC_W'(1);
    localparam int              DEPTH    = 6;
    localparam logic [2:0]      FULL     = 3'd6;
    localparam logic [2:0]      LAST_PTR = 3'd5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        PAD     = 2'd2,
        DISCARD = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;

    // Buffer storage: {last, data}
    logic [64:0]        mem_q [DEPTH];
    logic [2:0]         wptr_q, rptr_q, fcnt_q;
    logic               push, pop;
    logic [64:0]        push_word;

    // Emitter state: words still to send in the current triplet
    logic [1:0]         ecnt_q;
    logic               emit_start;
    logic [63:0]        payload_q;
    logic               valid_q, last_q;

    logic [CNT_W-1:0]   chunk_cnt_q;
    logic               err_short_q, err_long_q;
    logic               set_short, set_long;

    logic               room;
    logic               xfer_acc;
    logic               pad_push;
    logic               word_is_last;

    assign room         = (fcnt_q != FULL);
    assign xfer_acc     = (state_q == XFER) && s_axis_tvalid && room;
    assign pad_push     = (state_q == PAD) && room;
    assign word_is_last = (wcnt_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; space_avail_i only matters while idle so a started
    // chunk always runs to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (space_avail_i && (fcnt_q == 3'd0)) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (xfer_acc) begin
                    if (word_is_last) begin
                        state_d = s_axis_tlast ? IDLE : DISCARD;
                    end else if (s_axis_tlast) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                if (pad_push && word_is_last) begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Per-state outputs: handshake, buffer writes, word counter, error pulses
    always_comb begin
        s_axis_tready = 1'b0;
        push          = 1'b0;
        push_word     = '0;
        set_short     = 1'b0;
        set_long      = 1'b0;
        wcnt_d        = wcnt_q;
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
            end
            XFER: begin
                s_axis_tready = room;
                if (xfer_acc) begin
                    push      = 1'b1;
                    push_word = {word_is_last, s_axis_tdata};
                    wcnt_d    = wcnt_q + WC_ONE;
                    set_long  = word_is_last && !s_axis_tlast;
                    set_short = !word_is_last && s_axis_tlast;
                end
            end
            PAD: begin
                if (pad_push) begin
                    push      = 1'b1;
                    push_word = {word_is_last, 64'd0};
                    wcnt_d    = wcnt_q + WC_ONE;
                end
            end
            DISCARD: begin
                s_axis_tready = 1'b1;
            end
        endcase
    end

    // Word counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    // Buffer storage; contents are don't-care until counted in
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= push_word;
        end
    end

    // Buffer pointers and occupancy; push and pop may happen together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= 3'd0;
            rptr_q <= 3'd0;
            fcnt_q <= 3'd0;
        end else begin
            if (push) begin
                wptr_q <= (wptr_q == LAST_PTR) ? 3'd0 : wptr_q + 3'd1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == LAST_PTR) ? 3'd0 : rptr_q + 3'd1;
            end
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 3'd1;
                2'b01:   fcnt_q <= fcnt_q - 3'd1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // A triplet starts only with three words already buffered, which
    // guarantees the following two pops never find the buffer empty.
    assign emit_start = (ecnt_q == 2'd0) && (fcnt_q >= 3'd3);
    assign pop        = emit_start || (ecnt_q != 2'd0);

    // Emitter: registered payload, zeroed whenever no word is presented
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ecnt_q    <= 2'd0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            payload_q <= 64'd0;
        end else if (pop) begin
            ecnt_q    <= emit_start ? 2'd2 : ecnt_q - 2'd1;
            valid_q   <= 1'b1;
            last_q    <= mem_q[rptr_q][64];
            payload_q <= mem_q[rptr_q][63:0];
        end else begin
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            payload_q <= 64'd0;
        end
    end

    // Completed-chunk counter (wraps) and sticky length errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chunk_cnt_q <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            if (valid_q && last_q) begin
                chunk_cnt_q <= chunk_cnt_q + CNT_W'(1);
            end
            if (set_short) begin
                err_short_q <= 1'b1;
            end
            if (set_long) begin
                err_long_q <= 1'b1;
            end
        end
    end

    assign payload_o       = payload_q;
    assign payload_valid_o = valid_q;
    assign payload_last_o  = last_q;
    assign chunk_count_o   = chunk_cnt_q;
    assign err_short_o     = err_short_q;
    assign err_long_o      = err_long_q;
    // Held until the final word of the last triplet has been presented.
    assign busy_o          = (state_q != IDLE) || (fcnt_q != 3'd0) ||
                             (ecnt_q != 2'd0) || valid_q;

endmodule

// File: tb/tb_event_chunk_feeder.sv
// Testbench for event_chunk_feeder: scoreboard of expected output words,
// filled as source words are accepted and drained as payload words appear.
module tb_event_chunk_feeder;

    localparam int L  = 384;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          space_avail_i;
    logic [63:0]   payload_o;
    logic          payload_valid_o;
    logic          payload_last_o;
    logic [CW-1:0] chunk_count_o;
    logic          err_short_o;
    logic          err_long_o;
    logic          busy_o;

    logic [64:0] exp_q[$];
    int  n_tests     = 0;
    int  n_fail      = 0;
    bit  mon_en      = 1'b0;
    int  run_len     = 0;
    bit  cnt_pend    = 1'b0;
    int  cnt_at_last = 0;
    int  exp_chunks  = 0;

    event_chunk_feeder #(
        .CHUNK_LEN(L),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .space_avail_i  (space_avail_i),
        .payload_o      (payload_o),
        .payload_valid_o(payload_valid_o),
        .payload_last_o (payload_last_o),
        .chunk_count_o  (chunk_count_o),
        .err_short_o    (err_short_o),
        .err_long_o     (err_long_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard compare, triplet run length, idle zeros,
    // and counter step one cycle after each last word.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cnt_pend) begin
                chk("count_step", 65'(chunk_count_o), 65'((cnt_at_last + 1) % (1 << CW)));
                cnt_pend = 1'b0;
            end
            if (payload_valid_o) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 65'(exp_q.size()), 65'd1);
                end else begin
                    chk("word", {payload_last_o, payload_o}, exp_q.pop_front());
                end
                if (payload_last_o) begin
                    cnt_pend    = 1'b1;
                    cnt_at_last = int'(chunk_count_o);
                end
            end else begin
                if (run_len != 0) begin
                    chk("triplet_run", 65'(run_len % 3), 65'd0);
                end
                run_len = 0;
                chk("idle_zero", {payload_last_o, payload_o}, 65'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        mon_en        = 1'b0;
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge clk);
        chk("rst_valid",  65'(payload_valid_o), 65'd0);
        chk("rst_data",   65'(payload_o),       65'd0);
        chk("rst_last",   65'(payload_last_o),  65'd0);
        chk("rst_count",  65'(chunk_count_o),   65'd0);
        chk("rst_eshort", 65'(err_short_o),     65'd0);
        chk("rst_elong",  65'(err_long_o),      65'd0);
        chk("rst_busy",   65'(busy_o),          65'd0);
        chk("rst_tready", 65'(s_axis_tready),   65'd0);
        exp_q.delete();
        run_len    = 0;
        cnt_pend   = 1'b0;
        exp_chunks = 0;
        rst_n      = 1'b1;
        mon_en     = 1'b1;
    endtask

    // Drive nwords source words (counter pattern tagged with cid); tlast on
    // word last_idx (-1: never); gap = percent of idle cycles; space_avail_i
    // drops when word drop_at is presented (-1: never).
    task automatic send_chunk(input int cid, input int nwords, input int last_idx,
                              input int gap, input int drop_at);
        int          i     = 0;
        int          stall = 0;
        int          mi    = 0;
        bit          disc  = 1'b0;
        logic        acc;
        logic [63:0] d;
        while (i < nwords) begin
            @(negedge clk);
            if (i == drop_at) space_avail_i = 1'b0;
            d             = {32'(cid), 32'(i)};
            s_axis_tvalid = ($urandom_range(0, 99) >= gap);
            s_axis_tdata  = d;
            s_axis_tlast  = (i == last_idx);
            #1;
            acc = s_axis_tvalid && s_axis_tready;
            if (acc) begin
                if (disc) begin
                    if (s_axis_tlast) disc = 1'b0;
                end else begin
                    if (mi == L - 1) begin
                        exp_q.push_back({1'b1, d});
                        if (!s_axis_tlast) disc = 1'b1;
                    end else begin
                        exp_q.push_back({1'b0, d});
                        if (s_axis_tlast) begin
                            for (int k = mi + 1; k < L; k++) begin
                                exp_q.push_back({(k == L - 1), 64'd0});
                            end
                        end
                    end
                    mi++;
                end
                i++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 200) begin
                    chk("drv_stall", 65'(stall), 65'd0);
                    break;
                end
            end
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || payload_valid_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 65'(exp_q.size()), 65'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_status(input logic es, input logic el);
        chk("count",     65'(chunk_count_o), 65'(exp_chunks % (1 << CW)));
        chk("err_short", 65'(err_short_o),   65'(es));
        chk("err_long",  65'(err_long_o),    65'(el));
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tdata  = 64'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        space_avail_i = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        space_avail_i = 1'b1;

        // Clean chunk, no source gaps
        send_chunk(1, L, L - 1, 0, -1);
        wait_done(); exp_chunks++; check_status(1'b0, 1'b0);

        // Clean chunks with 50% source gaps
        for (int c = 2; c <= 3; c++) begin
            send_chunk(c, L, L - 1, 50, -1);
            wait_done(); exp_chunks++; check_status(1'b0, 1'b0);
        end

        // space_avail_i dropped mid-chunk: chunk still completes, then stays idle
        send_chunk(4, L, L - 1, 0, 100);
        wait_done(); exp_chunks++; check_status(1'b0, 1'b0);
        chk("busy_idle", 65'(busy_o), 65'd0);

        // Source loaded while no space: nothing accepted
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {32'd5, 32'd0};
        s_axis_tlast  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            chk("hold_tready", 65'(s_axis_tready), 65'd0);
        end
        space_avail_i = 1'b1;
        send_chunk(5, L, L - 1, 0, -1);
        wait_done(); exp_chunks++; check_status(1'b0, 1'b0);

        // Short chunk: tlast on word 99, zero padding to full length
        send_chunk(6, 100, 99, 0, -1);
        wait_done(); exp_chunks++; check_status(1'b1, 1'b0);

        // Long chunk: 390 words, tlast on the 390th
        send_chunk(7, 390, 389, 0, -1);
        wait_done(); exp_chunks++; check_status(1'b1, 1'b1);

        // Two clean chunks; the counter wraps to 0 then reaches 1
        for (int c = 8; c <= 9; c++) begin
            send_chunk(c, L, L - 1, 0, -1);
            wait_done(); exp_chunks++; check_status(1'b1, 1'b1);
        end

        // Reset after word 200 of a chunk
        send_chunk(10, 200, -1, 0, -1);
        chk("busy_mid", 65'(busy_o), 65'd1);
        do_reset();

        // Normal chunk after reset
        send_chunk(11, L, L - 1, 0, -1);
        wait_done(); exp_chunks++; check_status(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
